// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the RAM request front-end.
package ram_pkg;

    localparam int unsigned RAM_DEPTH = 8;
    localparam int unsigned RAM_WIDTH = 8;

    // Address/pointer width; at least one bit so degenerate depths still elaborate
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must hold the value depth itself
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned RAM_AW = addr_w(RAM_DEPTH);

    typedef struct packed {
        logic                 write;
        logic [RAM_AW-1:0]    addr;
        logic [RAM_WIDTH-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Request and response valid/ready channels of the RAM front-end.
interface ram_req_ctrl_if #(
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_rsp_fifo.sv
// Synchronous response FIFO with occupancy output; pointers wrap modulo RSP_DEPTH.
module ram_rsp_fifo
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RSP_DEPTH = 4,
    localparam int unsigned CW       = cnt_w(RSP_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    occ
);
    localparam int unsigned PW = addr_w(RSP_DEPTH);

    logic [WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok   = pop && (occ != '0);
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; only pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop_ok})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request/response front-end for the single-port RAM: drives RAM pins from
// accepted requests and buffers read data under a credit scheme.
module ram_req_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RSP_DEPTH = 4,
    localparam int unsigned AW       = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    ram_req_ctrl_if.slave    bus,
    output logic             ram_w_en,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out,
    output logic             idle
);
    localparam int unsigned CW = cnt_w(RSP_DEPTH);

    logic          inflight;
    logic [CW-1:0] occ;
    logic [CW:0]   credits_used;
    logic          accept;
    logic          rd_accept;

    // A credit is held from read accept until its data leaves the FIFO,
    // so the push one edge later can never overflow.
    assign credits_used  = {1'b0, occ} + (CW + 1)'(inflight);
    assign bus.req_ready = !rst && (credits_used < (CW + 1)'(RSP_DEPTH));

    assign accept    = bus.req_valid && bus.req_ready;
    assign rd_accept = accept && !bus.req_write;

    assign ram_w_en    = accept && bus.req_write;
    assign ram_addr    = bus.req_addr;
    assign ram_data_in = bus.req_wdata;

    // RAM output is valid exactly one edge after the read address
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_accept;
        end
    end

    ram_rsp_fifo #(
        .WIDTH     (WIDTH),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_data_out),
        .pop       (bus.rsp_ready),
        .pop_data  (bus.rsp_rdata),
        .occ       (occ)
    );

    assign bus.rsp_valid = (occ != '0);
    assign idle          = (occ == '0) && !inflight;

endmodule
